// File: rtl/debug_unit_pkg.sv
// Shared constants for the debug unit: host command bytes, reply bytes,
// dump word layout and the controller state encoding.
package debug_unit_pkg;

  localparam logic [7:0] CMD_RESET = 8'h52;  // 'R'
  localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'
  localparam logic [7:0] CMD_CONT  = 8'h43;  // 'C'
  localparam logic [7:0] CMD_DUMP  = 8'h44;  // 'D'

  localparam logic [7:0] RPL_OK      = 8'h4B;  // 'K'
  localparam logic [7:0] RPL_HALT    = 8'h48;  // 'H'
  localparam logic [7:0] RPL_TIMEOUT = 8'h54;  // 'T'
  localparam logic [7:0] RPL_ERROR   = 8'h45;  // 'E'

  // Dump word index layout: 0 = PC, then registers, then memory words.
  localparam int unsigned DUMP_REG_BASE = 1;
  localparam int unsigned DUMP_MEM_BASE = 33;

  typedef enum logic [3:0] {
    StIdle,
    StRst,
    StStep,
    StRun,
    StReply,
    StTx,
    StSel,
    StLoad,
    StDumpTx
  } state_e;

endpackage

// File: rtl/debug_tx_serializer.sv
// Loads a word and sends it MSB first, one byte per tx handshake, then pulses
// o_done. i_one_byte sends only the top byte (used for single-byte replies).
module debug_tx_serializer #(
  parameter int unsigned NB = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_load,
  input  logic          i_one_byte,
  input  logic [NB-1:0] i_word,
  input  logic          i_tx_done,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_start,
  output logic          o_done
);

  localparam int unsigned NBYTES = NB / 8;
  localparam int unsigned CW     = $clog2(NBYTES + 1);

  logic          active_q;
  logic [CW-1:0] left_q;  // bytes still to send after the current one
  logic [NB-1:0] shift_q;
  logic [7:0]    tx_data_q;
  logic          tx_start_q;
  logic          done_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      active_q   <= 1'b0;
      left_q     <= '0;
      shift_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      if (i_load && !active_q) begin
        active_q   <= 1'b1;
        left_q     <= i_one_byte ? '0 : CW'(NBYTES - 1);
        tx_data_q  <= i_word[NB-1 -: 8];
        shift_q    <= i_word << 8;
        tx_start_q <= 1'b1;
      end else if (active_q && i_tx_done) begin
        if (left_q == '0) begin
          active_q <= 1'b0;
          done_q   <= 1'b1;
        end else begin
          left_q     <= left_q - CW'(1);
          tx_data_q  <= shift_q[NB-1 -: 8];
          shift_q    <= shift_q << 8;
          tx_start_q <= 1'b1;
        end
      end
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_done     = done_q;

endmodule

// File: rtl/debug_unit.sv
// Host command controller for the MIPS pipeline: step/run/reset/dump over UART bytes.
// Define DEBUG_UNIT_CYCLE_COUNT_EN to count steps and append the count to each dump.
module debug_unit
  import debug_unit_pkg::*;
#(
  parameter int unsigned NB           = 32,
  parameter int unsigned NB_REGS      = 5,
  parameter int unsigned MEM_WORDS    = 16,
  parameter int unsigned MAX_CYCLES   = 1024,
  parameter int unsigned RESET_CYCLES = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_tx_done,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_start,
  input  logic [NB-1:0]      i_mips_pc,
  input  logic [NB-1:0]      i_mips_register_data,
  input  logic [NB-1:0]      i_mips_data_memory,
  input  logic               i_halt,
  output logic               o_step,
  output logic               o_mips_reset,
  output logic [NB_REGS-1:0] o_mips_register_number,
  output logic [NB-1:0]      o_debug_address,
  output logic               o_busy
);

`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
  localparam int unsigned NUM_WORDS = DUMP_MEM_BASE + MEM_WORDS + 1;
`else
  localparam int unsigned NUM_WORDS = DUMP_MEM_BASE + MEM_WORDS;
`endif
  localparam int unsigned WW = $clog2(NUM_WORDS);
  localparam int unsigned RW = $clog2(MAX_CYCLES + 1);
  localparam int unsigned CW = $clog2(RESET_CYCLES + 1);
  localparam logic [WW-1:0] LAST_WORD = WW'(NUM_WORDS - 1);
  localparam logic [RW-1:0] RUN_LAST  = RW'(MAX_CYCLES - 1);
  localparam logic [CW-1:0] RST_LAST  = CW'(RESET_CYCLES - 1);

  state_e               state_q;
  logic [WW-1:0]        word_q;
  logic [RW-1:0]        run_cnt_q;
  logic [CW-1:0]        rst_cnt_q;
  logic [7:0]           reply_q;
  logic [NB_REGS-1:0]   reg_num_q;
  logic [NB-1:0]        addr_q;

  logic [WW-1:0]        next_word;
  logic [NB_REGS-1:0]   sel_reg;
  logic [NB-1:0]        sel_addr;
  logic [NB-1:0]        dump_word;
  logic                 ser_load;
  logic                 ser_one;
  logic [NB-1:0]        ser_word;
  logic                 ser_done;

  assign next_word = (state_q == StIdle) ? '0 : word_q + WW'(1);

  // Select values for the word about to be dumped; registered on entry to StSel.
  always_comb begin
    sel_reg  = '0;
    sel_addr = '0;
    if (32'(next_word) >= DUMP_REG_BASE && 32'(next_word) < DUMP_MEM_BASE) begin
      sel_reg = NB_REGS'(32'(next_word) - DUMP_REG_BASE);
    end
    if (32'(next_word) >= DUMP_MEM_BASE && 32'(next_word) < DUMP_MEM_BASE + MEM_WORDS) begin
      sel_addr = NB'((32'(next_word) - DUMP_MEM_BASE) << 2);
    end
  end

`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
  logic [31:0] cyc_cnt_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cyc_cnt_q <= '0;
    end else if (state_q == StIdle && i_rx_valid && i_rx_data == CMD_RESET) begin
      cyc_cnt_q <= '0;
    end else if (o_step) begin
      cyc_cnt_q <= cyc_cnt_q + 32'd1;
    end
  end
`endif

  always_comb begin
    dump_word = i_mips_data_memory;
    if (word_q == '0) begin
      dump_word = i_mips_pc;
    end else if (32'(word_q) < DUMP_MEM_BASE) begin
      dump_word = i_mips_register_data;
`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
    end else if (32'(word_q) >= DUMP_MEM_BASE + MEM_WORDS) begin
      dump_word = NB'(cyc_cnt_q);
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= StIdle;
      word_q    <= '0;
      run_cnt_q <= '0;
      rst_cnt_q <= '0;
      reply_q   <= '0;
      reg_num_q <= '0;
      addr_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_rx_valid) begin
            case (i_rx_data)
              CMD_RESET: begin
                rst_cnt_q <= '0;
                state_q   <= StRst;
              end
              CMD_STEP: begin
                reply_q <= RPL_HALT;
                state_q <= i_halt ? StReply : StStep;
              end
              CMD_CONT: begin
                reply_q   <= RPL_HALT;
                run_cnt_q <= '0;
                state_q   <= i_halt ? StReply : StRun;
              end
              CMD_DUMP: begin
                word_q    <= next_word;
                reg_num_q <= sel_reg;
                addr_q    <= sel_addr;
                state_q   <= StSel;
              end
              default: begin
                reply_q <= RPL_ERROR;
                state_q <= StReply;
              end
            endcase
          end
        end
        StRst: begin
          if (rst_cnt_q == RST_LAST) begin
            reply_q <= RPL_OK;
            state_q <= StReply;
          end else begin
            rst_cnt_q <= rst_cnt_q + CW'(1);
          end
        end
        StStep: begin
          reply_q <= RPL_OK;
          state_q <= StReply;
        end
        // A cycle with i_halt low is a step; halt masks o_step combinationally.
        StRun: begin
          if (i_halt) begin
            reply_q <= RPL_HALT;
            state_q <= StReply;
          end else if (run_cnt_q == RUN_LAST) begin
            reply_q <= RPL_TIMEOUT;
            state_q <= StReply;
          end else begin
            run_cnt_q <= run_cnt_q + RW'(1);
          end
        end
        StReply: state_q <= StTx;
        StTx: begin
          if (ser_done) state_q <= StIdle;
        end
        StSel:  state_q <= StLoad;
        StLoad: state_q <= StDumpTx;
        StDumpTx: begin
          if (ser_done) begin
            if (word_q == LAST_WORD) begin
              state_q <= StIdle;
            end else begin
              word_q    <= next_word;
              reg_num_q <= sel_reg;
              addr_q    <= sel_addr;
              state_q   <= StSel;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ser_load = (state_q == StReply) || (state_q == StLoad);
  assign ser_one  = (state_q == StReply);
  assign ser_word = (state_q == StReply) ? {reply_q, {(NB - 8){1'b0}}} : dump_word;

  debug_tx_serializer #(
    .NB (NB)
  ) u_ser (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (ser_load),
    .i_one_byte (ser_one),
    .i_word     (ser_word),
    .i_tx_done  (i_tx_done),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .o_done     (ser_done)
  );

  assign o_step = (state_q == StStep) || (state_q == StRun && !i_halt);
  assign o_mips_reset = !i_reset || (state_q == StRst);
  assign o_mips_register_number = reg_num_q;
  assign o_debug_address = addr_q;
  assign o_busy = (state_q != StIdle);

endmodule

// File: tb/tb_debug_unit.sv
// Directed bench for debug_unit: table of single-command vectors plus run, dump
// and reset-abort sequences against a small pipeline/UART model.
module tb_debug_unit;

  localparam int unsigned MAXC = 16;
`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
  localparam int NDUMP = 4 * (33 + 16 + 1);
`else
  localparam int NDUMP = 4 * (33 + 16);
`endif

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_valid = 1'b0;
  logic        i_tx_done = 1'b0;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic [31:0] i_mips_pc;
  logic [31:0] i_mips_register_data;
  logic [31:0] i_mips_data_memory;
  logic        i_halt = 1'b0;
  logic        o_step;
  logic        o_mips_reset;
  logic [4:0]  o_mips_register_number;
  logic [31:0] o_debug_address;
  logic        o_busy;

  debug_unit #(
    .NB           (32),
    .NB_REGS      (5),
    .MEM_WORDS    (16),
    .MAX_CYCLES   (MAXC),
    .RESET_CYCLES (4)
  ) dut (
    .i_clk                  (i_clk),
    .i_reset                (i_reset),
    .i_rx_data              (i_rx_data),
    .i_rx_valid             (i_rx_valid),
    .i_tx_done              (i_tx_done),
    .o_tx_data              (o_tx_data),
    .o_tx_start             (o_tx_start),
    .i_mips_pc              (i_mips_pc),
    .i_mips_register_data   (i_mips_register_data),
    .i_mips_data_memory     (i_mips_data_memory),
    .i_halt                 (i_halt),
    .o_step                 (o_step),
    .o_mips_reset           (o_mips_reset),
    .o_mips_register_number (o_mips_register_number),
    .o_debug_address        (o_debug_address),
    .o_busy                 (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Pipeline model: PC = 0x10, reg k = 3k, mem word k = 0xA0 + k.
  always_comb begin
    i_mips_pc            = 32'h10;
    i_mips_register_data = 32'(o_mips_register_number) * 32'd3;
    i_mips_data_memory   = 32'hA0 + (o_debug_address >> 2);
  end

  int checks = 0;
  int errors = 0;
  int step_cnt = 0;
  int mrst_cnt = 0;
  int tx_cnt = 0;
  int overlap_err = 0;
  int hold_err = 0;
  logic [7:0] tx_last = 8'h00;
  logic [7:0] txq[$];

  always @(negedge i_clk) begin
    if (o_step) step_cnt++;
    if (i_reset && o_mips_reset) mrst_cnt++;
  end

  // Transmitter model: i_tx_done pulses three cycles after each o_tx_start.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      tx_cnt    = 0;
      i_tx_done = 1'b0;
    end else begin
      i_tx_done = 1'b0;
      if (tx_cnt > 0) begin
        if (o_tx_data !== tx_last) hold_err++;
        tx_cnt--;
        if (tx_cnt == 0) i_tx_done = 1'b1;
      end
      if (o_tx_start) begin
        if (tx_cnt != 0) overlap_err++;
        tx_last = o_tx_data;
        txq.push_back(o_tx_data);
        tx_cnt = 3;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge i_clk);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    while (o_busy && n < bound) begin
      @(negedge i_clk);
      n++;
    end
    check({name, "_idle"}, {31'd0, o_busy}, 32'd0);
    repeat (6) @(negedge i_clk);
  endtask

  function automatic logic [7:0] byte_at(input int i);
    if (i < txq.size()) return txq[i];
    return 8'hxx;
  endfunction

  function automatic logic [31:0] exp_word(input int w);
    if (w == 0) return 32'h10;
    if (w < 33) return 32'(w - 1) * 32'd3;
    if (w < 33 + 16) return 32'hA0 + 32'(w - 33);
    return 32'd3;  // step count after 'R' + 3 x 'S'
  endfunction

  typedef struct {
    logic [7:0] cmd;
    logic       halt;
    logic [7:0] reply;
    int         steps;
    int         mrst;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int bad;
    int n0;
    logic [31:0] w;

    vecs[0] = '{cmd: 8'h53, halt: 1'b0, reply: 8'h4B, steps: 1,    mrst: 0};
    vecs[1] = '{cmd: 8'h53, halt: 1'b1, reply: 8'h48, steps: 0,    mrst: 0};
    vecs[2] = '{cmd: 8'h43, halt: 1'b1, reply: 8'h48, steps: 0,    mrst: 0};
    vecs[3] = '{cmd: 8'h58, halt: 1'b0, reply: 8'h45, steps: 0,    mrst: 0};
    vecs[4] = '{cmd: 8'h52, halt: 1'b0, reply: 8'h4B, steps: 0,    mrst: 4};
    vecs[5] = '{cmd: 8'h43, halt: 1'b0, reply: 8'h54, steps: MAXC, mrst: 0};

    repeat (3) @(negedge i_clk);
    #1;
    check("rst_step", {31'd0, o_step}, 32'd0);
    check("rst_tx_start", {31'd0, o_tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, o_tx_data}, 32'd0);
    check("rst_regnum", {27'd0, o_mips_register_number}, 32'd0);
    check("rst_addr", o_debug_address, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_mips_reset", {31'd0, o_mips_reset}, 32'd1);
    @(negedge i_clk);
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    check("post_rst_mips_reset", {31'd0, o_mips_reset}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      i_halt = vecs[i].halt;
      step_cnt = 0;
      mrst_cnt = 0;
      txq.delete();
      send_byte(vecs[i].cmd);
      wait_idle($sformatf("vec%0d", i), 200);
      check($sformatf("vec%0d_nbytes", i), txq.size(), 32'd1);
      check($sformatf("vec%0d_reply", i), {24'd0, byte_at(0)}, {24'd0, vecs[i].reply});
      check($sformatf("vec%0d_steps", i), step_cnt, vecs[i].steps);
      check($sformatf("vec%0d_mrst", i), mrst_cnt, vecs[i].mrst);
    end

    // 'C' with halt retiring after the seventh step.
    i_halt = 1'b0;
    step_cnt = 0;
    txq.delete();
    send_byte(8'h43);
    for (int n = 0; n < 100 && step_cnt < 7; n++) begin
      @(posedge i_clk);
      #1;
    end
    i_halt = 1'b1;
    wait_idle("run_halt", 200);
    check("run_halt_steps", step_cnt, 32'd7);
    check("run_halt_nbytes", txq.size(), 32'd1);
    check("run_halt_reply", {24'd0, byte_at(0)}, 32'h48);
    i_halt = 1'b0;

    // 'R', three single steps, then a dump with two 'S' bytes arriving mid-dump.
    send_byte(8'h52);
    wait_idle("pre_r", 200);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h53);
      wait_idle("pre_s", 200);
    end
    step_cnt = 0;
    txq.delete();
    send_byte(8'h44);
    repeat (3) @(negedge i_clk);
    send_byte(8'h53);
    send_byte(8'h53);
    wait_idle("dump", 5000);
    check("dump_len", txq.size(), NDUMP);
    check("dump_steps", step_cnt, 32'd0);
    check("dump_pc", {byte_at(0), byte_at(1), byte_at(2), byte_at(3)}, 32'h10);
    check("dump_reg5", {byte_at(24), byte_at(25), byte_at(26), byte_at(27)}, 32'h0F);
    check("dump_mem15", {24'd0, byte_at(4 * 48 + 3)}, 32'hAF);
`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
    check("dump_cycles", {byte_at(NDUMP - 4), byte_at(NDUMP - 3), byte_at(NDUMP - 2),
                          byte_at(NDUMP - 1)}, 32'd3);
`endif
    bad = 0;
    for (int i = 0; i < NDUMP; i++) begin
      w = exp_word(i / 4);
      if (byte_at(i) !== w[8 * (3 - i % 4) +: 8]) bad++;
    end
    check("dump_bytes_bad", bad, 32'd0);

    // Reset pulled low mid-dump aborts with no further bytes.
    txq.delete();
    send_byte(8'h44);
    repeat (40) @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    n0 = txq.size();
    check("abort_busy", {31'd0, o_busy}, 32'd0);
    check("abort_tx_start", {31'd0, o_tx_start}, 32'd0);
    check("abort_tx_data", {24'd0, o_tx_data}, 32'd0);
    check("abort_step", {31'd0, o_step}, 32'd0);
    check("abort_mips_reset", {31'd0, o_mips_reset}, 32'd1);
    check("abort_regnum", {27'd0, o_mips_register_number}, 32'd0);
    check("abort_addr", o_debug_address, 32'd0);
    repeat (3) @(negedge i_clk);
    i_reset = 1'b1;
    repeat (60) @(negedge i_clk);
    check("abort_no_more_tx", txq.size(), n0);
    check("abort_idle", {31'd0, o_busy}, 32'd0);

    check("tx_overlap", overlap_err, 32'd0);
    check("tx_data_hold", hold_err, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
